board_input_conditioner: RTL

Parametrised, multi-channel conditioner for slow board-level inputs (joystick, user DIP switches, software-select switches, external interrupt lines) sitting between the top-level pins and the GPIO/interrupt fabric of the system. Per channel it:
- synchronises the raw pin into the system clock domain,
- applies a fixed per-channel polarity,
- debounces the level,
- generates one-cycle rise/fall pulses,
- maintains sticky, software-clearable interrupt status with per-channel edge selection.

It replaces ad-hoc pin inversion with a single reusable block.

---
 rtl/sonata_pkg.sv | 17 +
 rtl/debounce_chan.sv | 92 +++++++++
 rtl/prim_flop_2sync.sv | 34 +++
 rtl/board_input_conditioner.sv | 60 ++++++
 4 files changed

// File: rtl/sonata_pkg.sv
// Shared types for the board-level input conditioning path.
package sonata_pkg;

  typedef enum logic [1:0] {
    IrqEdgeNone = 2'b00,
    IrqEdgeRise = 2'b01,
    IrqEdgeFall = 2'b10,
    IrqEdgeBoth = 2'b11
  } irq_edge_e;

  // True when the accepted edge on this channel is one the selected mode reports.
  function automatic logic irq_edge_hit(irq_edge_e mode, logic rise, logic fall);
    return (rise && (mode == IrqEdgeRise || mode == IrqEdgeBoth)) ||
           (fall && (mode == IrqEdgeFall || mode == IrqEdgeBoth));
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One conditioned input: synchroniser, polarity fix, debounce counter and
// registered rise/fall pulses that coincide with the first cycle of a new level.
module debounce_chan #(
  parameter int unsigned SyncStages     = 2,
  parameter int unsigned DebounceCycles = 16,
  parameter bit          ActiveLow      = 1'b1,
  parameter int unsigned CntWidth       = $clog2(DebounceCycles + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [CntWidth-1:0] CntMax = CntWidth'(DebounceCycles - 1);

  logic sync_out;
  logic sync_lvl;

  // Synchroniser resets to the inactive pin level so nothing moves out of reset.
  if (SyncStages == 2) begin : g_prim_sync
    prim_flop_2sync #(
      .Width     (1),
      .ResetValue(ActiveLow)
    ) u_sync (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .d_i   (raw_i),
      .q_o   (sync_out)
    );
  end else begin : g_chain_sync
    logic [SyncStages-1:0] chain_d, chain_q;

    // Shift the raw pin through the local chain.
    always_comb chain_d = {chain_q[SyncStages-2:0], raw_i};

    // Local synchroniser chain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) chain_q <= {SyncStages{ActiveLow}};
      else         chain_q <= chain_d;
    end

    assign sync_out = chain_q[SyncStages-1];
  end

  assign sync_lvl = sync_out ^ ActiveLow;

  logic                stable_d, stable_q;
  logic [CntWidth-1:0] cnt_d, cnt_q;
  logic                rise_d, rise_q;
  logic                fall_d, fall_q;

  // Count consecutive mismatch cycles; accept the new level on the last one.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (sync_lvl == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      stable_d = sync_lvl;
      cnt_d    = '0;
      rise_d   = sync_lvl;
      fall_d   = ~sync_lvl;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Debounce state and edge pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign level_o = stable_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/prim_flop_2sync.sv
// Two-flop synchroniser with a configurable reset value.
module prim_flop_2sync #(
  parameter int unsigned      Width      = 16,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] sync1_d, sync1_q;
  logic [Width-1:0] sync2_d, sync2_q;

  // Next-state of the two synchroniser stages.
  always_comb begin
    sync1_d = d_i;
    sync2_d = sync1_q;
  end

  // Synchroniser stages.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= ResetValue;
      sync2_q <= ResetValue;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign q_o = sync2_q;

endmodule

// File: rtl/board_input_conditioner.sv
// Multi-channel conditioner for slow board inputs with sticky edge interrupts.
module board_input_conditioner
  import sonata_pkg::*;
#(
  parameter int unsigned          NumInputs      = 16,
  parameter logic [NumInputs-1:0] ActiveLowMask  = '1,
  parameter int unsigned          SyncStages     = 2,
  parameter int unsigned          DebounceCycles = 16,
  parameter int unsigned          CntWidth       = $clog2(DebounceCycles + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumInputs-1:0]   raw_i,
  input  logic [2*NumInputs-1:0] irq_mode_i,
  input  logic [NumInputs-1:0]   irq_clear_i,
  output logic [NumInputs-1:0]   level_o,
  output logic [NumInputs-1:0]   rise_o,
  output logic [NumInputs-1:0]   fall_o,
  output logic [NumInputs-1:0]   irq_status_o,
  output logic                   irq_o
);

  for (genvar i = 0; i < NumInputs; i++) begin : g_chan
    debounce_chan #(
      .SyncStages    (SyncStages),
      .DebounceCycles(DebounceCycles),
      .ActiveLow     (ActiveLowMask[i]),
      .CntWidth      (CntWidth)
    ) u_chan (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .raw_i  (raw_i[i]),
      .level_o(level_o[i]),
      .rise_o (rise_o[i]),
      .fall_o (fall_o[i])
    );
  end

  logic [NumInputs-1:0] irq_set;
  logic [NumInputs-1:0] irq_status_d, irq_status_q;

  // A new event wins over a clear landing in the same cycle.
  always_comb begin
    irq_set = '0;
    for (int unsigned i = 0; i < NumInputs; i++) begin
      irq_set[i] = irq_edge_hit(irq_edge_e'(irq_mode_i[2*i +: 2]), rise_o[i], fall_o[i]);
    end
    irq_status_d = irq_set | (irq_status_q & ~irq_clear_i);
  end

  // Sticky interrupt status register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) irq_status_q <= '0;
    else         irq_status_q <= irq_status_d;
  end

  assign irq_status_o = irq_status_q;
  assign irq_o        = |irq_status_q;

endmodule
